// File: rtl/mem_wb_multi_pkg.sv
// Shared constants and types for the multi-issue MEM/WB pipeline register.
`default_nettype none

package mem_wb_multi_pkg;

  localparam logic STOP         = 1'b1;
  localparam logic NOSTOP       = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b0;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr = 5'd0;

  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2
  } wb_act_e;

endpackage

`default_nettype wire

// File: rtl/mem_wb_multi_if.sv
// MEM-side inputs and WB-side outputs of the multi-issue MEM/WB register.
`default_nettype none

interface mem_wb_multi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2
);

  logic [NUM_CH-1:0]        mem_valid;
  logic [NUM_CH*ADDR_W-1:0] mem_wd;
  logic [NUM_CH-1:0]        mem_wreg;
  logic [NUM_CH*DATA_W-1:0] mem_wdata;
  logic                     mem_whilo_i;
  logic [DATA_W-1:0]        mem_hi_i;
  logic [DATA_W-1:0]        mem_lo_i;
  logic                     mem_LLbit_we_i;
  logic                     mem_LLbit_value_i;

  logic [NUM_CH-1:0]        wb_valid;
  logic [NUM_CH*ADDR_W-1:0] wb_wd;
  logic [NUM_CH-1:0]        wb_wreg;
  logic [NUM_CH*DATA_W-1:0] wb_wdata;
  logic                     wb_whilo_o;
  logic [DATA_W-1:0]        wb_hi_o;
  logic [DATA_W-1:0]        wb_lo_o;
  logic                     wb_LLbit_we;
  logic                     wb_LLbit_value;

  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo_i, mem_hi_i, mem_lo_i,
           mem_LLbit_we_i, mem_LLbit_value_i,
    input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo_o, wb_hi_o, wb_lo_o,
           wb_LLbit_we, wb_LLbit_value
  );

  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo_i, mem_hi_i, mem_lo_i,
           mem_LLbit_we_i, mem_LLbit_value_i,
    output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo_o, wb_hi_o, wb_lo_o,
           wb_LLbit_we, wb_LLbit_value
  );

endinterface

`default_nettype wire

// File: rtl/mem_wb_collide.sv
// Write-enable qualification, same-bundle collision masking and valid popcount.
`default_nettype none

module mem_wb_collide
  import mem_wb_multi_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int ADDR_W = 5,
  localparam int POP_W  = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0]        mem_valid_i,
  input  logic [NUM_CH-1:0]        mem_wreg_i,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd_i,
  output logic [NUM_CH-1:0]        wreg_o,
  output logic [POP_W-1:0]         pop_o
);

  logic [NUM_CH-1:0] wr;

  always_comb begin
    wr     = '0;
    wreg_o = '0;
    pop_o  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = mem_valid_i[i] && (mem_wreg_i[i] == WriteEnable) &&
              (mem_wd_i[i*ADDR_W +: ADDR_W] != ADDR_W'(NOPRegAddr));
    end
    // The youngest writer of an address keeps its enable; older ones are dropped.
    for (int i = 0; i < NUM_CH; i++) begin
      wreg_o[i] = wr[i];
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (wr[j] && (mem_wd_i[j*ADDR_W +: ADDR_W] == mem_wd_i[i*ADDR_W +: ADDR_W]))
          wreg_o[i] = WriteDisable;
      end
      pop_o = pop_o + POP_W'(mem_valid_i[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_multi.sv
// Multi-issue MEM/WB pipeline register with stall/bubble/flush and retire counter.
`default_nettype none

module mem_wb_multi
  import mem_wb_multi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_CH    = 2,
  parameter int STAGE_IDX = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  mem_wb_multi_if.slave     bus,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  localparam int POP_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0]        valid_q, valid_d, wreg_q, wreg_d, wreg_masked;
  logic [NUM_CH*ADDR_W-1:0] wd_q, wd_d;
  logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;
  logic                     whilo_q, whilo_d, llwe_q, llwe_d, llv_q, llv_d;
  logic [DATA_W-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [POP_W-1:0]         pop;
  logic                     any_valid;
  logic                     unused_stall;
  wb_act_e                  act;

  assign unused_stall = ^stall_i;
  assign any_valid    = |bus.mem_valid;

  mem_wb_collide #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_collide (
    .mem_valid_i (bus.mem_valid),
    .mem_wreg_i  (bus.mem_wreg),
    .mem_wd_i    (bus.mem_wd),
    .wreg_o      (wreg_masked),
    .pop_o       (pop)
  );

  // Flush beats any stall combination.
  always_comb begin
    act = ACT_CAPTURE;
    if (flush_i)
      act = ACT_BUBBLE;
    else if (stall_i[STAGE_IDX] == STOP)
      act = (stall_i[STAGE_IDX+1] == STOP) ? ACT_HOLD : ACT_BUBBLE;
  end

  always_comb begin
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    llwe_d  = llwe_q;
    llv_d   = llv_q;
    cnt_d   = cnt_q;
    case (act)
      ACT_BUBBLE: begin
        valid_d = '0;
        wd_d    = {NUM_CH{ADDR_W'(NOPRegAddr)}};
        wreg_d  = {NUM_CH{WriteDisable}};
        wdata_d = {NUM_CH{DATA_W'(ZeroWord)}};
        whilo_d = WriteDisable;
        hi_d    = DATA_W'(ZeroWord);
        lo_d    = DATA_W'(ZeroWord);
        llwe_d  = WriteDisable;
        llv_d   = 1'b0;
      end
      ACT_CAPTURE: begin
        valid_d = bus.mem_valid;
        wd_d    = bus.mem_wd;
        wreg_d  = wreg_masked;
        wdata_d = bus.mem_wdata;
        whilo_d = bus.mem_whilo_i & any_valid;
        hi_d    = bus.mem_hi_i;
        lo_d    = bus.mem_lo_i;
        llwe_d  = bus.mem_LLbit_we_i & any_valid;
        llv_d   = bus.mem_LLbit_value_i;
        cnt_d   = cnt_q + CNT_W'(pop);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RstEnable) begin
      valid_q <= '0;
      wd_q    <= {NUM_CH{ADDR_W'(NOPRegAddr)}};
      wreg_q  <= {NUM_CH{WriteDisable}};
      wdata_q <= {NUM_CH{DATA_W'(ZeroWord)}};
      whilo_q <= WriteDisable;
      hi_q    <= DATA_W'(ZeroWord);
      lo_q    <= DATA_W'(ZeroWord);
      llwe_q  <= WriteDisable;
      llv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      llwe_q  <= llwe_d;
      llv_q   <= llv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_valid       = valid_q;
  assign bus.wb_wd          = wd_q;
  assign bus.wb_wreg        = wreg_q;
  assign bus.wb_wdata       = wdata_q;
  assign bus.wb_whilo_o     = whilo_q;
  assign bus.wb_hi_o        = hi_q;
  assign bus.wb_lo_o        = lo_q;
  assign bus.wb_LLbit_we    = llwe_q;
  assign bus.wb_LLbit_value = llv_q;
  assign retire_cnt_o       = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_multi.sv
// Self-checking bench for mem_wb_multi against a last-writer-wins reference model.
`default_nettype none

module tb_mem_wb_multi;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 2;
  localparam int SI = 4;
  localparam int CW = 4;
  localparam int VW = NC + NC*AW + NC + NC*DW + 1 + 2*DW + 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    stall = 6'd0;
  logic          flush = 1'b0;
  logic [CW-1:0] retire_cnt;
  int            checks = 0;
  int            errors = 0;

  logic [NC-1:0]    e_valid, e_wreg;
  logic [NC*AW-1:0] e_wd;
  logic [NC*DW-1:0] e_wdata;
  logic             e_whilo, e_llwe, e_llv;
  logic [DW-1:0]    e_hi, e_lo;
  logic [CW-1:0]    e_cnt;

  mem_wb_multi_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) bus ();

  mem_wb_multi #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .STAGE_IDX(SI), .CNT_W(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .bus          (bus),
    .retire_cnt_o (retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.wb_valid, bus.wb_wd, bus.wb_wreg, bus.wb_wdata, bus.wb_whilo_o,
            bus.wb_hi_o, bus.wb_lo_o, bus.wb_LLbit_we, bus.wb_LLbit_value};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_valid, e_wd, e_wreg, e_wdata, e_whilo, e_hi, e_lo, e_llwe, e_llv};
  endfunction

  task automatic model_clear(input bit keep_cnt);
    e_valid = '0; e_wd = '0; e_wreg = '0; e_wdata = '0;
    e_whilo = 0;  e_hi = '0; e_lo = '0;   e_llwe = 0; e_llv = 0;
    if (!keep_cnt) e_cnt = '0;
  endtask

  // Next-state of the register, stated directly from the priority and capture rules.
  task automatic model_next();
    int last [32];
    int a;
    if (!rst_n) model_clear(0);
    else if (flush || (stall[SI] && !stall[SI+1])) model_clear(1);
    else if (!stall[SI]) begin
      for (int k = 0; k < 32; k++) last[k] = -1;
      for (int i = 0; i < NC; i++) begin
        a = int'(bus.mem_wd[i*AW +: AW]);
        if (bus.mem_valid[i] && bus.mem_wreg[i] && a != 0) last[a] = i;
      end
      for (int i = 0; i < NC; i++) begin
        a = int'(bus.mem_wd[i*AW +: AW]);
        e_wreg[i] = bus.mem_valid[i] && bus.mem_wreg[i] && a != 0 && last[a] == i;
      end
      e_valid = bus.mem_valid;  e_wd = bus.mem_wd;  e_wdata = bus.mem_wdata;
      e_whilo = bus.mem_whilo_i && (bus.mem_valid != 0);
      e_hi    = bus.mem_hi_i;   e_lo = bus.mem_lo_i;
      e_llwe  = bus.mem_LLbit_we_i && (bus.mem_valid != 0);
      e_llv   = bus.mem_LLbit_value_i;
      e_cnt   = e_cnt + CW'($countones(bus.mem_valid));
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bundle();
    bus.mem_valid         = NC'($urandom);
    bus.mem_wreg          = NC'($urandom);
    for (int i = 0; i < NC; i++) begin
      bus.mem_wd[i*AW +: AW]    = AW'($urandom_range(0, 7));
      bus.mem_wdata[i*DW +: DW] = $urandom;
    end
    bus.mem_whilo_i       = 1'($urandom);
    bus.mem_hi_i          = $urandom;
    bus.mem_lo_i          = $urandom;
    bus.mem_LLbit_we_i    = 1'($urandom);
    bus.mem_LLbit_value_i = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      rand_bundle(); stall = 6'($urandom); flush = 1'($urandom);
      tick();
    end
    checks++;
    if (dut_vec() !== '0 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h cnt=%0d want=0 cnt=0", dut_vec(), retire_cnt);
    end
    @(negedge clk);
    rst_n = 1; stall = 0; flush = 0;
    rand_bundle();
    bus.mem_valid = 2'b11; bus.mem_wreg = 2'b11;
    bus.mem_wd = {5'd3, 5'd2}; bus.mem_wdata = {32'hB, 32'hA};
    tick();
    checks++;
    if (bus.wb_wd !== 10'h062 || bus.wb_wreg !== 2'b11 ||
        bus.wb_wdata !== {32'hB, 32'hA} || retire_cnt !== 4'd2) begin
      errors++;
      $display("FAIL first_capture got wd=%h wreg=%b wdata=%h cnt=%0d want wd=062 wreg=11 wdata=%h cnt=2",
               bus.wb_wd, bus.wb_wreg, bus.wb_wdata, retire_cnt, {32'hB, 32'hA});
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL first_capture_model got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_collision();
    stall = 0; flush = 0;
    bus.mem_valid = 2'b11; bus.mem_wreg = 2'b11;
    bus.mem_wd = {5'd7, 5'd7}; bus.mem_wdata = {32'h22, 32'h11};
    tick();
    checks++;
    if (bus.wb_wreg !== 2'b10 || bus.wb_wdata !== {32'h22, 32'h11} || bus.wb_wd !== {5'd7, 5'd7}) begin
      errors++;
      $display("FAIL collision got wreg=%b wdata=%h want wreg=10 wdata=%h",
               bus.wb_wreg, bus.wb_wdata, {32'h22, 32'h11});
    end
    bus.mem_wd = {5'd0, 5'd4};
    tick();
    checks++;
    if (bus.wb_wreg !== 2'b01 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reg0_suppress got wreg=%b want wreg=01", bus.wb_wreg);
    end
  endtask

  task automatic test_stall();
    logic [VW-1:0] snap;
    logic [CW-1:0] snap_cnt;
    stall = 0; flush = 0;
    rand_bundle(); bus.mem_valid = 2'b11;
    tick();
    snap_cnt = retire_cnt;
    rand_bundle(); bus.mem_valid = 2'b11; stall = 6'b011111;
    tick();
    checks++;
    if (dut_vec() !== '0 || retire_cnt !== snap_cnt || retire_cnt !== e_cnt) begin
      errors++;
      $display("FAIL stall_bubble got=%h cnt=%0d want=0 cnt=%0d", dut_vec(), retire_cnt, e_cnt);
    end
    stall = 0; rand_bundle(); bus.mem_valid = 2'b01;
    tick();
    snap = exp_vec(); snap_cnt = e_cnt;
    for (int c = 0; c < 3; c++) begin
      rand_bundle(); stall = 6'b111111;
      tick();
      checks++;
      if (dut_vec() !== snap || retire_cnt !== snap_cnt) begin
        errors++;
        $display("FAIL stall_hold[%0d] got=%h cnt=%0d want=%h cnt=%0d",
                 c, dut_vec(), retire_cnt, snap, snap_cnt);
      end
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] snap_cnt;
    snap_cnt = e_cnt;
    stall = 0; flush = 1;
    rand_bundle(); bus.mem_valid = 2'b11; bus.mem_whilo_i = 1; bus.mem_hi_i = 32'h5;
    tick();
    flush = 0;
    checks++;
    if (bus.wb_whilo_o !== 1'b0 || bus.wb_hi_o !== '0 || bus.wb_wreg !== '0 ||
        retire_cnt !== snap_cnt || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL flush got whilo=%b hi=%h wreg=%b cnt=%0d want 0 0 00 cnt=%0d",
               bus.wb_whilo_o, bus.wb_hi_o, bus.wb_wreg, retire_cnt, snap_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      rand_bundle();
      stall = 6'($urandom);
      stall[SI] = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || retire_cnt !== e_cnt) begin
        errors++;
        $display("FAIL random[%0d] got=%h cnt=%0d want=%h cnt=%0d",
                 n, dut_vec(), retire_cnt, exp_vec(), e_cnt);
      end
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_wrap();
    @(negedge clk); rst_n = 0;
    tick();
    @(negedge clk); rst_n = 1; stall = 0; flush = 0;
    for (int n = 0; n < 15; n++) begin
      rand_bundle(); bus.mem_valid = NC'(1 << $urandom_range(0, NC-1));
      tick();
    end
    checks++;
    if (retire_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_preload got cnt=%0d want cnt=15", retire_cnt);
    end
    rand_bundle(); bus.mem_valid = 2'b11;
    tick();
    checks++;
    if (retire_cnt !== 4'd1 || retire_cnt !== e_cnt) begin
      errors++;
      $display("FAIL wrap got cnt=%0d want cnt=1", retire_cnt);
    end
  endtask

  task automatic test_async_reset();
    stall = 0; flush = 0;
    rand_bundle(); bus.mem_valid = 2'b11;
    tick();
    stall = 6'b111111;
    tick();
    #2;
    rst_n = 0;
    #1;
    model_clear(0);
    checks++;
    if (dut_vec() !== '0 || retire_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h cnt=%0d want=0 cnt=0", dut_vec(), retire_cnt);
    end
    @(negedge clk);
    rst_n = 1; stall = 0;
    rand_bundle();
    tick();
    checks++;
    if (dut_vec() !== exp_vec() || retire_cnt !== e_cnt) begin
      errors++;
      $display("FAIL post_reset_capture got=%h cnt=%0d want=%h cnt=%0d",
               dut_vec(), retire_cnt, exp_vec(), e_cnt);
    end
  endtask

  initial begin
    model_clear(0);
    rand_bundle();
    test_reset();
    test_collision();
    test_stall();
    test_flush();
    test_random();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
Parametrised MEM/WB pipeline register for the multi-issue core. It carries NUM_CH general-register write-back channels, one HI/LO write and one LLbit update from the MEM stage to the WB stage. Supported actions are stall, bubble insertion, exception flush and same-bundle write-collision resolution. It also keeps a retired-instruction counter and sits between the mem stage and regfile/hilo_reg/LLbit_reg.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NUM_CH, 2, write-back channels per bundle (1..4)
STAGE_IDX, 4, bit of stall vector owned by this register; stall[STAGE_IDX+1] is the downstream bit
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
stall  in  6  pipeline stall vector from ctrl; 1 = STOP
flush  in  1  exception flush from ctrl
mem_valid  in  NUM_CH  channel i holds a real instruction
mem_wd  in  NUM_CH*ADDR_W  destination address, channel i at [i*ADDR_W +: ADDR_W]
mem_wreg  in  NUM_CH  write enable per channel
mem_wdata  in  NUM_CH*DATA_W  write data per channel
mem_whilo_i  in  1  HI/LO write enable
mem_hi_i, mem_lo_i  in  DATA_W each  HI/LO values
mem_LLbit_we_i, mem_LLbit_value_i  in  1 each  LLbit update
wb_valid  out  NUM_CH  registered valid
wb_wd  out  NUM_CH*ADDR_W  registered address
wb_wreg  out  NUM_CH  registered write enable, after collision masking
wb_wdata  out  NUM_CH*DATA_W  registered data
wb_whilo_o  out  1  registered HI/LO write enable
wb_hi_o, wb_lo_o  out  DATA_W each  registered HI/LO values
wb_LLbit_we, wb_LLbit_value  out  1 each  registered LLbit update
retire_cnt  out  CNT_W  count of valid instructions passed to WB

Behaviour:
- Latency: 1 cycle, MEM inputs to wb_* outputs.
- Reset (rst=0, asynchronous): all outputs 0, i.e. wb_wd=NOPRegAddr, wb_wreg=WriteDisable, data ZeroWord, retire_cnt=0. Release is on the next clk edge with no glitch; reset mid-bundle discards the bundle.
- Per-edge priority, highest first:
  1. flush=1: load a bubble (all outputs except retire_cnt go to 0), whatever the stall vector.
  2. stall[STAGE_IDX]=STOP and stall[STAGE_IDX+1]=NOSTOP: load a bubble.
  3. stall[STAGE_IDX]=STOP and stall[STAGE_IDX+1]=STOP: hold every output.
  4. stall[STAGE_IDX]=NOSTOP: capture.
- Capture rules:
  - wb_wreg[i] = mem_wreg[i] & mem_valid[i] & (mem_wd_i != 0). Writes to $0 are suppressed.
  - Collision: if valid channels i<j both write the same nonzero address, wb_wreg[i] is cleared. The youngest channel (highest index) wins. Address and data of channel i are still latched unchanged.
  - HI/LO and LLbit fields are latched as given. wb_whilo_o and wb_LLbit_we are forced to 0 if no channel is valid.
- retire_cnt:
  - Increments by popcount(mem_valid) on capture edges only. No increment on bubble, hold or flush.
  - Wraps modulo 2^CNT_W with no saturation. Cleared only by reset.
- Stall bits other than STAGE_IDX/STAGE_IDX+1 are ignored.
- NUM_CH=1 must behave as the single-issue MEM/WB register, plus the valid and counter outputs.

Decomposition:
- Shared package/define file: STOP/NOSTOP, WriteEnable/WriteDisable, ZeroWord, NOPRegAddr, RstEnable (active-low value 1'b0).
- One sub-module, mem_wb_collide: combinational, NUM_CH/ADDR_W parametrised. Inputs mem_valid, mem_wreg, mem_wd; outputs the masked wreg vector and the valid popcount.
- Instantiated once; the flop logic stays in mem_wb_multi.

Test Plan:
1. Reset: hold rst=0 with random inputs, release, then drive mem_valid=2'b11, mem_wd={5'd3,5'd2}, wdata={32'hB,32'hA}, stall=0 -> next edge wb_wd={3,2}, wb_wreg=2'b11, wb_wdata={B,A}, retire_cnt=2.
2. Collision: both channels write reg 7, data {32'h22,32'h11} -> wb_wreg=2'b10, wb_wdata={22,11}. A separate bundle writing reg 0 on channel 1 -> wb_wreg[1]=0.
3. Stall bubble/hold: stall=6'b011111 -> bubble, outputs 0, counter unchanged. stall=6'b111111 for 3 cycles -> outputs and counter hold the previous bundle.
4. Flush: flush=1 together with stall=0 and a valid bundle with mem_whilo_i=1, mem_hi_i=32'h5 -> wb_whilo_o=0, wb_hi_o=0, wb_wreg=0, retire_cnt unchanged.
5. Counter wrap: CNT_W=4, preload by 15 single-channel captures, then one dual-valid capture -> retire_cnt=1.
6. Async reset mid-hold: assert rst=0 between edges during stall=6'b111111 -> outputs go to 0 immediately, before the next clk edge.
